// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and state encoding for the instruction cache fetch port
package icache_pkg;

    // Default log2 of the number of cache lines (16 lines).
    localparam int ICACHE_INDEX_WIDTH = 4;

    typedef enum logic [1:0] {
        ICACHE_IDLE  = 2'd0,
        ICACHE_ISSUE = 2'd1,
        ICACHE_WAIT  = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data storage with combinational lookup and fill port
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset (clears valid bits only)
//   lookup_waddr  word address (byte address bits [31:2]) to look up
//   lookup_hit    line valid and tag matches
//   lookup_data   data word stored in the indexed line
//   fill_en       write the line selected by fill_waddr on the next rising edge
//   fill_waddr    word address of the line being filled
//   fill_data     word written into the line
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_waddr,
    output logic        lookup_hit,
    output logic [31:0] lookup_data,
    input  logic        fill_en,
    input  logic [29:0] fill_waddr,
    input  logic [31:0] fill_data
);

    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [31:0]          data_q [LINES];

    logic [INDEX_WIDTH-1:0] lookup_idx;
    logic [TAG_WIDTH-1:0]   lookup_tag;
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_WIDTH-1:0]   fill_tag;

    assign lookup_idx = lookup_waddr[INDEX_WIDTH-1:0];
    assign lookup_tag = lookup_waddr[29:INDEX_WIDTH];
    assign fill_idx   = fill_waddr[INDEX_WIDTH-1:0];
    assign fill_tag   = fill_waddr[29:INDEX_WIDTH];

    // Tag compare is only meaningful for valid lines; tag/data are never reset.
    assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign lookup_data = data_q[lookup_idx];

    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/icache_fetch_port.sv
// rtl/icache_fetch_port.sv - direct-mapped one-word-line icache between fetch unit and memory controller IC port
//
// Optional feature macro: ICACHE_PERF_EN (adds hit_count / miss_count outputs).
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   rdy          global ready; low freezes all state and outputs
//   fetch_req    fetch request, accepted only while fetch_busy is low
//   fetch_addr   fetch PC (bits [1:0] ignored)
//   fetch_flush  discard the in-flight fetch
//   fetch_busy   high whenever a miss is being serviced
//   fetch_rdy    one-cycle pulse, fetch_ins valid
//   fetch_ins    returned instruction word
//   ic_enable    memory controller can accept a request
//   ins, ins_rdy returned word and its one-cycle valid pulse
//   ic_flag      one-cycle request pulse to the memory controller
//   ins_addr     word-aligned miss address, stable until ins_rdy
//   hit_count, miss_count  (ICACHE_PERF_EN only) accepted hit / miss counters
module icache_fetch_port
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic        fetch_busy,
    output logic        fetch_rdy,
    output logic [31:0] fetch_ins,
    input  logic        ic_enable,
    input  logic [31:0] ins,
    input  logic        ins_rdy,
    output logic        ic_flag,
    output logic [31:0] ins_addr
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    icache_state_e state_q, state_d;
    logic          drop_q, drop_d;
    logic          fetch_rdy_q, fetch_rdy_d;
    logic [31:0]   fetch_ins_q, fetch_ins_d;
    logic          ic_flag_q, ic_flag_d;
    logic [31:0]   ins_addr_q, ins_addr_d;
    logic          fill_req;
    logic          lookup_hit;
    logic [31:0]   lookup_data;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
`endif

    icache_array #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .lookup_waddr (fetch_addr[31:2]),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .fill_en      (fill_req && rdy),
        .fill_waddr   (ins_addr_q[31:2]),
        .fill_data    (ins)
    );

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        fetch_rdy_d = 1'b0;
        fetch_ins_d = fetch_ins_q;
        ic_flag_d   = 1'b0;
        ins_addr_d  = ins_addr_q;
        fill_req    = 1'b0;
`ifdef ICACHE_PERF_EN
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`endif
        case (state_q)
            ICACHE_IDLE: begin
                if (!fetch_flush && fetch_req) begin
                    if (lookup_hit) begin
                        fetch_rdy_d = 1'b1;
                        fetch_ins_d = lookup_data;
`ifdef ICACHE_PERF_EN
                        hit_count_d = hit_count_q + 32'd1;
`endif
                    end else begin
                        ins_addr_d = fetch_addr & 32'hFFFF_FFFC;
                        drop_d     = 1'b0;
                        state_d    = ICACHE_ISSUE;
`ifdef ICACHE_PERF_EN
                        miss_count_d = miss_count_q + 32'd1;
`endif
                    end
                end
            end
            ICACHE_ISSUE: begin
                // Nothing is outstanding yet, so a flush simply abandons the miss.
                if (fetch_flush) begin
                    drop_d  = 1'b0;
                    state_d = ICACHE_IDLE;
                end else if (ic_enable) begin
                    ic_flag_d = 1'b1;
                    state_d   = ICACHE_WAIT;
                end
            end
            ICACHE_WAIT: begin
                if (ins_rdy) begin
                    fill_req = 1'b1;
                    state_d  = ICACHE_IDLE;
                    drop_d   = 1'b0;
                    if (!drop_q && !fetch_flush) begin
                        fetch_rdy_d = 1'b1;
                        fetch_ins_d = ins;
                    end
                end else if (fetch_flush) begin
                    // The request is already with the controller: let the fill land, suppress the return.
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ICACHE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ICACHE_IDLE;
            drop_q      <= 1'b0;
            fetch_rdy_q <= 1'b0;
            fetch_ins_q <= 32'd0;
            ic_flag_q   <= 1'b0;
            ins_addr_q  <= 32'd0;
`ifdef ICACHE_PERF_EN
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
`endif
        end else if (rdy) begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            fetch_rdy_q <= fetch_rdy_d;
            fetch_ins_q <= fetch_ins_d;
            ic_flag_q   <= ic_flag_d;
            ins_addr_q  <= ins_addr_d;
`ifdef ICACHE_PERF_EN
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`endif
        end
    end

    assign fetch_busy = (state_q != ICACHE_IDLE);
    assign fetch_rdy  = fetch_rdy_q;
    assign fetch_ins  = fetch_ins_q;
    assign ic_flag    = ic_flag_q;
    assign ins_addr   = ins_addr_q;
`ifdef ICACHE_PERF_EN
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_fetch_port.sv
// tb/tb_icache_fetch_port.sv - self-checking bench for icache_fetch_port
module tb_icache_fetch_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'd0;
    logic        fetch_flush = 1'b0;
    logic        fetch_busy;
    logic        fetch_rdy;
    logic [31:0] fetch_ins;
    logic        ic_enable = 1'b1;
    logic [31:0] ins;
    logic        ins_rdy;
    logic        ic_flag;
    logic [31:0] ins_addr;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_fetch_port dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_flush (fetch_flush),
        .fetch_busy  (fetch_busy),
        .fetch_rdy   (fetch_rdy),
        .fetch_ins   (fetch_ins),
        .ic_enable   (ic_enable),
        .ins         (ins),
        .ins_rdy     (ins_rdy),
        .ic_flag     (ic_flag),
        .ins_addr    (ins_addr)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: cache as per-line word address + data ----------------
    bit          m_valid [16];
    logic [31:0] m_waddr [16];
    logic [31:0] m_data  [16];
    bit          m_pending, m_sent, m_drop;
    logic        e_rdy, e_flag;
    logic [31:0] e_ins, e_addr;
    logic [31:0] m_hits, m_misses;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_pending = 0; m_sent = 0; m_drop = 0;
        e_rdy = 0; e_flag = 0; e_ins = 0; e_addr = 0;
        m_hits = 0; m_misses = 0;
    endtask

    task automatic model_step();
        int line;
        e_rdy  = 1'b0;
        e_flag = 1'b0;
        if (!m_pending) begin
            if (!fetch_flush && fetch_req) begin
                line = int'((fetch_addr >> 2) % 16);
                if (m_valid[line] && m_waddr[line] == (fetch_addr >> 2)) begin
                    e_rdy = 1'b1;
                    e_ins = m_data[line];
                    m_hits++;
                end else begin
                    m_pending = 1; m_sent = 0; m_drop = 0;
                    e_addr = (fetch_addr >> 2) << 2;
                    m_misses++;
                end
            end
        end else if (!m_sent) begin
            if (fetch_flush) m_pending = 0;
            else if (ic_enable) begin
                m_sent = 1;
                e_flag = 1'b1;
            end
        end else begin
            if (ins_rdy) begin
                line = int'((e_addr >> 2) % 16);
                m_valid[line] = 1'b1;
                m_waddr[line] = e_addr >> 2;
                m_data[line]  = ins;
                m_pending = 0;
                if (!m_drop && !fetch_flush) begin
                    e_rdy = 1'b1;
                    e_ins = ins;
                end
                m_drop = 0;
            end else if (fetch_flush) m_drop = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else if (rdy) model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy",      {31'd0, fetch_busy}, {31'd0, m_pending});
                check("fetch_rdy", {31'd0, fetch_rdy},  {31'd0, e_rdy});
                check("ic_flag",   {31'd0, ic_flag},    {31'd0, e_flag});
                if (m_pending) check("ins_addr", ins_addr, e_addr);
                if (e_rdy)     check("fetch_ins", fetch_ins, e_ins);
`ifdef ICACHE_PERF_EN
                check("hit_count",  hit_count,  m_hits);
                check("miss_count", miss_count, m_misses);
`endif
            end
        end
    end

    // ---------------- memory controller model ----------------
    int          mem_lat = 3;
    logic [31:0] next_ins = 32'd0;
    int          flag_pulses = 0;
    int          rdy_pulses = 0;
    logic [31:0] flag_addr = 32'd0;

    initial begin
        ins_rdy = 1'b0;
        ins     = 32'd0;
        forever begin
            @(negedge clk);
            if (ic_flag === 1'b1) begin
                flag_pulses++;
                flag_addr = ins_addr;
                repeat (mem_lat) @(negedge clk);
                ins     = next_ins;
                ins_rdy = 1'b1;
                @(negedge clk);
                ins_rdy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fetch_rdy === 1'b1) rdy_pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fetch(input logic [31:0] a);
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req  = 1'b0;
    endtask

    task automatic wait_rdy(input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (fetch_rdy === 1'b1) found = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: fetch_rdy not seen within 40 cycles", name);
        end
    endtask

    task automatic wait_flag(input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ic_flag === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: ic_flag not seen within 40 cycles", name);
        end
    endtask

    int p0, r0;

    initial begin
        // reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy",    {31'd0, fetch_busy}, 32'd0);
        check("reset_ins_addr", ins_addr, 32'd0);
        check("reset_fetch_ins", fetch_ins, 32'd0);

        // cold miss
        next_ins = 32'h00A00093;
        p0 = flag_pulses;
        fetch(32'h0000_0010);
        wait_rdy("cold_miss");
        check("cold_ins", fetch_ins, 32'h00A00093);
        check("cold_flag_pulses", flag_pulses - p0, 32'd1);
        check("cold_flag_addr", flag_addr, 32'h0000_0010);

        // hit: one-cycle latency, no memory request
        p0 = flag_pulses;
        fetch(32'h0000_0013);
        check("hit_latency", {31'd0, fetch_rdy}, 32'd1);
        check("hit_ins", fetch_ins, 32'h00A00093);
        // back-to-back hits
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h10;
        repeat (3) @(negedge clk);
        fetch_req = 1'b0;
        check("hit_no_flag", flag_pulses - p0, 32'd0);

        // conflict on same index
        next_ins = 32'h1111_1111;
        fetch(32'h0000_0050);
        wait_rdy("conflict_miss");
        check("conflict_addr", flag_addr, 32'h0000_0050);
        next_ins = 32'h00A00093;
        p0 = flag_pulses;
        fetch(32'h0000_0010);
        wait_rdy("conflict_refill");
        check("conflict_refetch_pulses", flag_pulses - p0, 32'd1);

        // backpressure
        ic_enable = 1'b0;
        next_ins  = 32'h2222_2222;
        p0 = flag_pulses;
        fetch(32'h0000_0020);
        repeat (5) @(negedge clk);
        check("bp_no_flag", flag_pulses - p0, 32'd0);
        check("bp_busy", {31'd0, fetch_busy}, 32'd1);
        ic_enable = 1'b1;
        wait_rdy("bp_return");
        check("bp_one_flag", flag_pulses - p0, 32'd1);
        check("bp_ins", fetch_ins, 32'h2222_2222);

        // rdy low freezes a hit
        @(negedge clk);
        rdy = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h20;
        r0 = rdy_pulses;
        repeat (3) @(negedge clk);
        check("rdy_low_no_rdy", rdy_pulses - r0, 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("rdy_resume_hit", {31'd0, fetch_rdy}, 32'd1);

        // flush in WAIT
        mem_lat  = 5;
        next_ins = 32'hDEAD_BEEF;
        r0 = rdy_pulses;
        fetch(32'h0000_0030);
        wait_flag("flush_wait_flag");
        repeat (2) @(negedge clk);
        fetch_flush = 1'b1;
        @(negedge clk);
        fetch_flush = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_no_rdy", rdy_pulses - r0, 32'd0);
        check("flush_idle", {31'd0, fetch_busy}, 32'd0);
        fetch(32'h0000_0030);
        check("flush_fill_hit", {31'd0, fetch_rdy}, 32'd1);
        check("flush_fill_ins", fetch_ins, 32'hDEAD_BEEF);

        // flush in ISSUE: no request issued
        ic_enable = 1'b0;
        p0 = flag_pulses;
        fetch(32'h0000_0040);
        fetch_flush = 1'b1;
        @(negedge clk);
        fetch_flush = 1'b0;
        check("issue_flush_idle", {31'd0, fetch_busy}, 32'd0);
        ic_enable = 1'b1;
        repeat (4) @(negedge clk);
        check("issue_flush_no_flag", flag_pulses - p0, 32'd0);

        // top address
        mem_lat  = 3;
        next_ins = 32'h3333_3333;
        fetch(32'hFFFF_FFFC);
        wait_rdy("top_miss");
        repeat (2) @(negedge clk);
        fetch(32'hFFFF_FFFF);
        check("top_hit", {31'd0, fetch_rdy}, 32'd1);
        check("top_ins", fetch_ins, 32'h3333_3333);

        // async reset mid-WAIT
        fetch(32'h0000_0010);
        check("pre_reset_hit", {31'd0, fetch_rdy}, 32'd1);
        mem_lat = 6;
        fetch(32'h0000_0060);
        wait_flag("reset_flag");
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_ic_flag", {31'd0, ic_flag},    32'd0);
        check("async_rdy",     {31'd0, fetch_rdy},  32'd0);
        check("async_busy",    {31'd0, fetch_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        mem_lat  = 3;
        next_ins = 32'h4444_4444;
        fetch(32'h0000_0010);
        check("post_reset_miss", {31'd0, fetch_busy}, 32'd1);
        wait_rdy("post_reset_fill");
        check("post_reset_ins", fetch_ins, 32'h4444_4444);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
